// File: rtl/instruction_timing_sequencer_if.sv
// Bus bundle between the instruction timing sequencer and its surroundings.
// The slave side is the sequencer. The master side drives the fetch/interrupt
// inputs and observes the opcode and timing outputs.
interface instruction_timing_sequencer_if;
  logic       ready;
  logic [7:0] dataBusIn;
  logic       endOfInstruction;
  logic       nmiN;
  logic       irqN;
  logic       interruptMask;
  logic [7:0] instructionReg;
  logic [2:0] timingState;
  logic       sync;
  logic       interruptActive;
  logic [1:0] vectorSelect;
  logic       sequenceError;

  modport master (
    output ready, dataBusIn, endOfInstruction, nmiN, irqN, interruptMask,
    input  instructionReg, timingState, sync, interruptActive, vectorSelect,
           sequenceError
  );

  modport slave (
    input  ready, dataBusIn, endOfInstruction, nmiN, irqN, interruptMask,
    output instructionReg, timingState, sync, interruptActive, vectorSelect,
           sequenceError
  );
endinterface

// File: rtl/instruction_timing_sequencer.sv
// Instruction timing sequencer: latches the fetched opcode, counts the
// instruction's T-states and folds reset, NMI and IRQ into a forced BRK.
// The opcode and T-count feed decode; vectorSelect feeds interrupt address
// generation.
module instruction_timing_sequencer #(
  parameter int         MAX_T         = 7,
  parameter logic [7:0] FORCED_OPCODE = 8'h00
) (
  input logic clk,
  input logic nrst,
  instruction_timing_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    VEC_NONE  = 2'b00,
    VEC_NMI   = 2'b01,
    VEC_RESET = 2'b10,
    VEC_IRQ   = 2'b11
  } vector_t;

  localparam logic [2:0] MAX_T3 = 3'(MAX_T);

  logic [7:0] instrQ, instrD;
  logic [2:0] tsQ, tsD;
  logic       activeQ, activeD;
  vector_t    vecQ, vecD;
  logic       errQ, errD;
  logic       nmiPrev;
  logic       nmiPending, nmiPendingD;
  logic       nmiEdge;
  logic       nmiTaken;

  // Next-state decode: fetch arbitration at T0, counting/saturation afterwards.
  // A stall holds everything; only the NMI edge detector keeps running.
  always_comb begin
    instrD   = instrQ;
    tsD      = tsQ;
    activeD  = activeQ;
    vecD     = vecQ;
    errD     = errQ;
    nmiTaken = 1'b0;
    nmiEdge  = nmiPrev & ~bus.nmiN;

    if (bus.ready) begin
      if (tsQ == 3'd0) begin
        tsD = 3'd1;
        if (nmiPending) begin
          instrD   = FORCED_OPCODE;
          vecD     = VEC_NMI;
          activeD  = 1'b1;
          nmiTaken = 1'b1;
        end else if (!bus.irqN && !bus.interruptMask) begin
          instrD  = FORCED_OPCODE;
          vecD    = VEC_IRQ;
          activeD = 1'b1;
        end else begin
          instrD  = bus.dataBusIn;
          vecD    = VEC_NONE;
          activeD = 1'b0;
        end
      end else if (bus.endOfInstruction) begin
        tsD = 3'd0;
      end else if (tsQ < MAX_T3) begin
        tsD = tsQ + 3'd1;
      end else begin
        errD = 1'b1;
      end
    end

    // A fresh falling edge on the very cycle the request is consumed must
    // survive, so the edge term is ORed in after the clear.
    nmiPendingD = nmiEdge | (nmiPending & ~nmiTaken);
  end

  // State register; reset forces the BRK sequence to start at T1 via RESET.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      instrQ     <= FORCED_OPCODE;
      tsQ        <= 3'd1;
      activeQ    <= 1'b1;
      vecQ       <= VEC_RESET;
      errQ       <= 1'b0;
      nmiPrev    <= 1'b1;
      nmiPending <= 1'b0;
    end else begin
      instrQ     <= instrD;
      tsQ        <= tsD;
      activeQ    <= activeD;
      vecQ       <= vecD;
      errQ       <= errD;
      nmiPrev    <= bus.nmiN;
      nmiPending <= nmiPendingD;
    end
  end

  assign bus.instructionReg  = instrQ;
  assign bus.timingState     = tsQ;
  assign bus.sync            = (tsQ == 3'd0);
  assign bus.interruptActive = activeQ;
  assign bus.vectorSelect    = vecQ;
  assign bus.sequenceError   = errQ;

endmodule

// File: doc/instruction_timing_sequencer.md
Name: instruction_timing_sequencer

Overview:
- Cycle sequencer directly upstream of the internal dataflow.
- Latches each opcode fetched from the external data bus and tracks the instruction's timing state (T-count).
- Arbitrates reset, NMI and IRQ into a forced BRK sequence.
- Its instruction-register and timing outputs feed the decode logic that drives the dataflow control flags. It also supplies the vector select used for interrupt address generation.

Parameters:
- MAX_T, 7: highest timing state; the counter never exceeds it.
- FORCED_OPCODE, 8'h00: opcode injected on reset or interrupt service (BRK).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- nrst  input  1  asynchronous active-low reset.
- ready  input  1  RDY; 0 stalls the sequencer, holding all state except the NMI edge detector.
- dataBusIn  input  8  external data bus; holds the opcode during a fetch cycle.
- endOfInstruction  input  1  from decode: the current cycle is the instruction's last.
- nmiN  input  1  active-low NMI, edge-triggered.
- irqN  input  1  active-low IRQ, level-sensitive.
- interruptMask  input  1  processor I flag; 1 masks IRQ.
- instructionReg  output  8  current opcode.
- timingState  output  3  current T-count, 0..MAX_T.
- sync  output  1  high while timingState==0 (fetch cycle).
- interruptActive  output  1  a forced BRK (reset, NMI or IRQ) is executing.
- vectorSelect  output  2  00 none/BRK, 01 NMI, 10 RESET, 11 IRQ.
- sequenceError  output  1  sticky: MAX_T reached without endOfInstruction.

Behaviour:
- Reset (nrst low, async):
  - instructionReg=FORCED_OPCODE, timingState=1, sync=0, interruptActive=1, vectorSelect=10, sequenceError=0.
  - NMI pending=0; NMI previous-sample register=1.
  - After release, the reset BRK sequence runs from T1. Reset asserted mid-instruction aborts immediately to these values.
- Stall: ready=0 freezes instructionReg, timingState, interruptActive, vectorSelect and sequenceError. Outputs hold stable.
- Fetch cycle (timingState==0, ready=1):
  - If NMI pending: instructionReg=FORCED_OPCODE, vectorSelect=01, interruptActive=1; clear NMI pending.
  - Else if irqN==0 and interruptMask==0: instructionReg=FORCED_OPCODE, vectorSelect=11, interruptActive=1.
  - Else: instructionReg=dataBusIn, vectorSelect=00, interruptActive=0.
  - timingState becomes 1 in all cases. endOfInstruction is ignored at T0 (minimum instruction length is 2 cycles).
- Execute cycles (timingState>=1, ready=1):
  - endOfInstruction=1: timingState becomes 0 next cycle. instructionReg, vectorSelect and interruptActive hold until the next fetch cycle updates them.
  - Else if timingState<MAX_T: increment.
  - Else: hold at MAX_T and set sequenceError (cleared only by reset). endOfInstruction still returns to 0.
- NMI detection:
  - Sample nmiN every clock regardless of ready.
  - Previous=1 and current=0 sets pending.
  - If a new falling edge coincides with the fetch that clears pending, pending stays set (the new edge wins).
  - A held-low nmiN produces exactly one request.
- IRQ: sampled only at fetch; no latching. Deasserting before fetch loses the request.
- Priority at fetch: NMI > IRQ > normal fetch. Reset overrides all.
- sync is combinational from timingState==0.

Test Plan:
- Reset release, ready=1, endOfInstruction at T6 → vectorSelect=10, interruptActive=1, instructionReg=8'h00, timingState 1→6→0; next fetch with dataBusIn=8'hA9 → instructionReg=8'hA9, vectorSelect=00.
- Fetch 8'hA9, endOfInstruction at T1 → timingState sequence 0,1,0,1; sync high exactly on the T0 cycles.
- ready=0 for 3 cycles at T2 with dataBusIn toggling → all outputs frozen; T3 follows once ready returns.
- Falling edge on nmiN during a stall with irqN=0, interruptMask=0 → next fetch loads 8'h00, vectorSelect=01; IRQ served at the following fetch with vectorSelect=11. With interruptMask=1, IRQ is ignored.
- nmiN held low for 20 cycles across two fetches → only one NMI service.
- endOfInstruction never asserted → timingState saturates at 7 with sequenceError=1; after endOfInstruction, timingState=0 and sequenceError stays 1 until nrst.
